// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction-memory responder. Serves fetch requests from a
//               DEPTH x 32 program store after WAIT_STATES wait cycles,
//               using a req/ack handshake, with a program-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 2
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ack,
    output logic [31:0]       Inst_code,
    output logic              fetch_err,
    output logic              busy,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_wait_last = 4'(WAIT_STATES);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_inst;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_ack;
    logic               w_busy;
    logic               w_addr_err;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_load_resp;

    assign w_idx       = r_addr[ADDR_W+1:2];
    assign w_addr_err  = (|r_addr[1:0]) || (|r_addr[31:ADDR_W+2]);
    assign w_load_resp = (r_state == S_WAIT) && (r_cnt == c_wait_last);

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The WAIT state always lasts at least one cycle so the response appears
    // WAIT_STATES+1 edges after acceptance, including when WAIT_STATES is 0.
    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_req) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == c_wait_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_busy = 1'b1;
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 4'd0;
            r_addr <= 32'h0000_0000;
            r_inst <= 32'h0000_0000;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && fetch_req) begin
                r_addr <= fetch_addr;
                r_cnt  <= 4'd0;
            end else if (r_state == S_WAIT && !w_load_resp) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // Same-edge program writes land after this read: read-before-write.
            if (w_load_resp) begin
                r_inst <= w_addr_err ? 32'h0000_0000 : r_mem[w_idx];
                r_err  <= w_addr_err;
            end
        end
    end

    // Program store is deliberately left out of reset.
    always_ff @(posedge clka) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign fetch_ack = w_ack;
    assign busy      = w_busy;
    assign Inst_code = r_inst;
    assign fetch_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Scoreboard bench for imem_responder, WAIT_STATES=2 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
    logic [31:0] inst_a, inst_b;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_STATES(2)) u_dut_a (
        .clka(clk), .rst(rst_n), .fetch_req(req_a), .fetch_addr(addr_a),
        .fetch_ack(ack_a), .Inst_code(inst_a), .fetch_err(err_a), .busy(busy_a),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_STATES(0)) u_dut_b (
        .clka(clk), .rst(rst_n), .fetch_req(req_b), .fetch_addr(addr_b),
        .fetch_ack(ack_b), .Inst_code(inst_b), .fetch_err(err_b), .busy(busy_b),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat_a = 0, lat_b = 0;
    logic pb_a = 1'b0, pb_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        return x;
    endfunction

    // Monitors: latency counts negedge samples since busy rose.
    always @(negedge clk) begin
        if (busy_a && !pb_a) lat_a = 0;
        else if (busy_a) lat_a++;
        pb_a = busy_a;
        if (ack_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                $display("FAIL ack_a_unexpected: got ack with inst %h, expected no ack", inst_a);
            end else begin
                e_a = q_a.pop_front();
                check("inst_a", inst_a, e_a.data);
                check("err_a", {31'b0, err_a}, {31'b0, e_a.err});
                check("latency_a", 32'(lat_a), 32'd3);
                check("busy_a_at_ack", {31'b0, busy_a}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (busy_b && !pb_b) lat_b = 0;
        else if (busy_b) lat_b++;
        pb_b = busy_b;
        if (ack_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                $display("FAIL ack_b_unexpected: got ack with inst %h, expected no ack", inst_b);
            end else begin
                e_b = q_b.pop_front();
                check("inst_b", inst_b, e_b.data);
                check("err_b", {31'b0, err_b}, {31'b0, e_b.err});
                check("latency_b", 32'(lat_b), 32'd1);
                check("busy_b_at_ack", {31'b0, busy_b}, 32'd1);
            end
        end
    end

    task automatic wait_ack(input bit which);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = which ? ack_b : ack_a;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ack_timeout: got no ack within 40 cycles, expected ack on dut %0d", which);
        end
    endtask

    task automatic do_fetch(input bit which, input logic [31:0] addr,
                            input logic [31:0] d, input logic e);
        @(negedge clk);
        if (which) begin
            q_b.push_back(mk(d, e)); req_b = 1'b1; addr_b = addr;
        end else begin
            q_a.push_back(mk(d, e)); req_a = 1'b1; addr_a = addr;
        end
        wait_ack(which);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = idx; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack_a", {31'b0, ack_a}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_err_a", {31'b0, err_a}, 32'd0);
        check("rst_inst_a", inst_a, 32'h0);
        check("rst_inst_b", inst_b, 32'h0);
        check("rst_busy_b", {31'b0, busy_b}, 32'd0);
        rst_n = 1'b1;

        load(6'd0, 32'h2001_0005);
        load(6'd1, 32'h2002_0007);
        load(6'd2, 32'h0022_1820);
        load(6'd3, 32'hAC03_0000);

        do_fetch(0, 32'h0000_0000, 32'h2001_0005, 1'b0);
        do_fetch(0, 32'h0000_0004, 32'h2002_0007, 1'b0);
        do_fetch(0, 32'h0000_0008, 32'h0022_1820, 1'b0);
        do_fetch(0, 32'h0000_000C, 32'hAC03_0000, 1'b0);
        do_fetch(0, 32'h0000_0002, 32'h0000_0000, 1'b1);
        do_fetch(0, 32'h0000_0100, 32'h0000_0000, 1'b1);
        do_fetch(0, 32'h8000_0004, 32'h0000_0000, 1'b1);

        do_fetch(1, 32'h0000_0008, 32'h0022_1820, 1'b0);
        // Held request on the zero-wait instance: two acks, each re-accepted from IDLE.
        @(negedge clk);
        q_b.push_back(mk(32'h2001_0005, 1'b0));
        q_b.push_back(mk(32'h2001_0005, 1'b0));
        req_b = 1'b1; addr_b = 32'h0;
        wait_ack(1);
        wait_ack(1);
        req_b = 1'b0;

        // Address changes during WAIT must not affect the latched request.
        @(negedge clk);
        q_a.push_back(mk(32'h2002_0007, 1'b0));
        q_a.push_back(mk(32'h0022_1820, 1'b0));
        req_a = 1'b1; addr_a = 32'h4;
        @(negedge clk);
        addr_a = 32'h8;
        wait_ack(0);
        wait_ack(0);
        req_a = 1'b0;

        // Program write on the edge that enters RESP: old word returned.
        @(negedge clk);
        q_a.push_back(mk(32'h2002_0007, 1'b0));
        req_a = 1'b1; addr_a = 32'h4;
        repeat (3) @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'hDEAD_BEEF;
        wait_ack(0);
        prog_we = 1'b0;
        req_a = 1'b0;
        do_fetch(0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0);

        // Asynchronous reset during WAIT drops the request.
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h0;
        @(negedge clk);
        check("busy_a_pre_reset", {31'b0, busy_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack_a", {31'b0, ack_a}, 32'd0);
        check("async_rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("async_rst_inst_a", inst_a, 32'h0);
        check("async_rst_err_a", {31'b0, err_a}, 32'd0);
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_fetch(0, 32'h0000_0000, 32'h2001_0005, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
